// File: rtl/hybrid_adder_pipe.sv
// Pipelined add/subtract: WIDTH/BLK registered carry-lookahead slices, one slice per stage,
// carries rippling stage-to-stage, valid/ready flow control with a single global advance.
module hybrid_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int unsigned NSTG = WIDTH / BLK;

  if (BLK < 1 || (WIDTH % BLK) != 0) begin : g_bad_params
    $error("hybrid_adder_pipe: WIDTH must be a nonzero multiple of BLK");
  end

  // Full lookahead: C[i] = c0&P[0..i-1] | OR_j ( G[j] & P[j+1..i-1] ).
  function automatic logic [BLK:0] cla_carries(input logic [BLK-1:0] p,
                                               input logic [BLK-1:0] g,
                                               input logic           c0);
    logic [BLK:0] c;
    logic         term;
    c = '0;
    for (int i = 0; i <= int'(BLK); i++) begin
      term = c0;
      for (int m = 0; m < i; m++) term = term & p[m];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  // Stage inputs: stage 0 from the ports, stage k from the stage k-1 registers.
  logic [WIDTH-1:0] a_in [NSTG];
  logic [WIDTH-1:0] b_in [NSTG];
  logic [WIDTH-1:0] s_in [NSTG];
  logic [NSTG-1:0]  c_in;

  logic [WIDTH-1:0] s_d  [NSTG];
  logic [BLK:0]     cc   [NSTG];
  logic [NSTG-1:0]  c_d;

  logic [WIDTH-1:0] a_q  [NSTG];
  logic [WIDTH-1:0] b_q  [NSTG];
  logic [WIDTH-1:0] s_q  [NSTG];
  logic [NSTG-1:0]  c_q;
  logic [NSTG-1:0]  valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             adv;

  assign adv      = ~valid_q[NSTG-1] | out_ready;
  assign in_ready = adv;

  assign a_in[0] = in_a;
  assign b_in[0] = in_sub ? ~in_b : in_b;
  assign s_in[0] = '0;
  assign c_in[0] = in_sub | in_cin;

  for (genvar k = 1; k < NSTG; k++) begin : g_link
    assign a_in[k] = a_q[k-1];
    assign b_in[k] = b_q[k-1];
    assign s_in[k] = s_q[k-1];
    assign c_in[k] = c_q[k-1];
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    assign p      = a_in[k][k*BLK +: BLK] ^ b_in[k][k*BLK +: BLK];
    assign g      = a_in[k][k*BLK +: BLK] & b_in[k][k*BLK +: BLK];
    assign cc[k]  = cla_carries(p, g, c_in[k]);
    // Lower slices are already final and upper slices still zero, so OR-merge is exact.
    assign s_d[k] = s_in[k] | (WIDTH'(p ^ cc[k][BLK-1:0]) << (k * BLK));
    assign c_d[k] = cc[k][BLK];
  end

  assign ovf_d   = cc[NSTG-1][BLK] ^ cc[NSTG-1][BLK-1];
  assign valid_d = (valid_q << 1) | NSTG'(in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < int'(NSTG); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < int'(NSTG); k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign out_valid = valid_q[NSTG-1];
  assign out_sum   = s_q[NSTG-1];
  assign out_cout  = c_q[NSTG-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_hybrid_adder_pipe.sv
// Directed bench for hybrid_adder_pipe at WIDTH=16, BLK=4: arithmetic corners, latency,
// back-pressure ordering and mid-flight reset.
module tb_hybrid_adder_pipe;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf;
  logic [15:0] out_sum;

  int n_cmp = 0;
  int n_bad = 0;

  hybrid_adder_pipe #(.WIDTH(16), .BLK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered shortly after a rising edge; returns shortly after a rising edge.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input logic [15:0] es,
                       input logic ec, input logic eo);
    int lat;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, LAT);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".sum"}, out_sum, es);
    chk({tag, ".cout"}, out_cout, ec);
    chk({tag, ".ovf"}, out_ovf, eo);
    @(posedge clk); #1;
    chk({tag, ".drained"}, out_valid, 0);
  endtask

  initial begin
    int issued, recv, stray;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    #12;
    chk("reset.out_valid", out_valid, 0);
    chk("reset.out_sum", out_sum, 0);
    chk("reset.out_cout", out_cout, 0);
    chk("reset.out_ovf", out_ovf, 0);
    chk("reset.in_ready", in_ready, 1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("sub_brw", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    do_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Eight back-to-back ops, consumer stalls in cycles 5..7; op i yields 0x1001*i.
    issued = 0; recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (issued < 8);
      in_a      = 16'(issued);
      in_b      = 16'(issued * 16'h1000);
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      #1;
      if (out_valid) begin
        chk($sformatf("stream.sum%0d", recv), out_sum, 16'h1001 * recv);
        chk($sformatf("stream.cout%0d", recv), out_cout, 0);
        if (!out_ready) chk($sformatf("stream.stall_rdy%0d", cyc), in_ready, 0);
      end
      if (out_valid && out_ready) recv++;
      if (in_valid && in_ready) issued++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream.issued", issued, 8);
    chk("stream.received", recv, 8);
    chk("stream.empty", out_valid, 0);

    // Fill the pipe with out_ready low, then reset while a result is presented.
    out_ready = 1'b0; in_sub = 1'b0; in_cin = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      in_valid = 1'b1; in_a = 16'h0100 + 16'(i); in_b = 16'h0001;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("rst.pre_valid", out_valid, 1);
    chk("rst.pre_sum", out_sum, 16'h0101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.valid_drop", out_valid, 0);
    chk("rst.sum_clear", out_sum, 0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    chk("rst.no_stale", stray, 0);
    do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
